// File: rtl/spi_word_rx.sv
// ============================================================================
// Module   : spi_word_rx
// Brief    : 3-wire serial receiver. Synchronises cs/sclk/sdo, deserialises
//            MSB-first frames and strobes good words or frame errors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_word_rx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             sclk,
  input  logic             sdo,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  localparam int BCW = $clog2(WIDTH + 2);
  localparam logic [BCW-1:0] BIT_FULL = BCW'(WIDTH);
  localparam logic [BCW-1:0] BIT_OVR  = BCW'(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdo_sync;
  logic cs_s, sclk_s, sdo_s;
  logic cs_p, sclk_p, sdo_p;
  logic cs_fall_r, cs_rise_r, sclk_rise_r;

  logic [BCW-1:0]   bit_cnt;
  logic [WIDTH-1:0] shift;

  logic clr, shift_en, load, err;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sdo_s  = sdo_sync[SYNC_STAGES-1];

  // Idle-line presets keep reset release from looking like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      sclk_sync <= '1;
      sdo_sync  <= '0;
      cs_p      <= 1'b1;
      sclk_p    <= 1'b1;
      sdo_p     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdo_sync  <= {sdo_sync[SYNC_STAGES-2:0], sdo};
      cs_p      <= cs_s;
      sclk_p    <= sclk_s;
      sdo_p     <= sdo_s;
    end
  end

  // Edges are registered; sdo_p is captured on the same edge as sclk_rise_r,
  // so it is the bit that belongs to that rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_fall_r   <= 1'b0;
      cs_rise_r   <= 1'b0;
      sclk_rise_r <= 1'b0;
    end else begin
      cs_fall_r   <= ~cs_s & cs_p;
      cs_rise_r   <= cs_s & ~cs_p;
      sclk_rise_r <= sclk_s & ~sclk_p;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // cs_rise takes priority over a coincident sclk_rise: that bit is dropped.
  always_comb begin
    state_next = state;
    clr        = 1'b0;
    shift_en   = 1'b0;
    load       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall_r) begin
          state_next = RECV;
          clr        = 1'b1;
        end
      end
      RECV: begin
        if (cs_rise_r) begin
          state_next = IDLE;
          if (bit_cnt == BIT_FULL) begin
            load = 1'b1;
          end else begin
            err = 1'b1;
          end
        end else if (sclk_rise_r) begin
          shift_en = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if (shift_en) begin
      shift <= {shift[WIDTH-2:0], sdo_p};
      if (bit_cnt != BIT_OVR) begin
        bit_cnt <= bit_cnt + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data        <= '0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      valid     <= load;
      frame_err <= err;
      if (load) begin
        data        <= shift;
        frame_count <= frame_count + CNT_W'(1);
      end
    end
  end

  assign busy = (state == RECV);

endmodule

`default_nettype wire

// File: tb/tb_spi_word_rx.sv
// Directed/randomised bench for spi_word_rx with a frame-level reference model.
`default_nettype none

module tb_spi_word_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs = 1'b1;
  logic sclk = 1'b1;
  logic sdo = 1'b0;

  logic [15:0] data, data2;
  logic        valid, frame_err, busy, valid2, frame_err2, busy2;
  logic [7:0]  frame_count;
  logic [1:0]  frame_count2;

  spi_word_rx #(.WIDTH(16), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .sdo(sdo),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy),
    .frame_count(frame_count)
  );

  spi_word_rx #(.WIDTH(16), .SYNC_STAGES(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .sdo(sdo),
    .data(data2), .valid(valid2), .frame_err(frame_err2), .busy(busy2),
    .frame_count(frame_count2)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int misses  = 0;

  // Monitor: counts strobe cycles and collects words seen on valid.
  int mon_valid = 0, mon_err = 0, mon_both = 0;
  logic [15:0] got_q[$];

  always @(negedge clk) begin
    if (rst) begin
      mon_valid = 0;
      mon_err   = 0;
      mon_both  = 0;
      got_q.delete();
    end else begin
      if (valid) begin
        mon_valid++;
        got_q.push_back(data);
      end
      if (frame_err) mon_err++;
      if (valid && frame_err) mon_both++;
    end
  end

  // Reference model: frame-level outcome counts and expected word stream.
  int          exp_good = 0;
  int          exp_err  = 0;
  logic [15:0] exp_data = '0;
  logic [15:0] exp_q[$];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sclk = 1'b0;
      sdo  = v[i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      if (i == n - 1) chk("busy_mid", {31'b0, busy}, 32'd1);
    end
  endtask

  task automatic frame(input logic [31:0] v, input int n);
    cs = 1'b0;
    wait_clk(4);
    send_bits(v, n);
    if (n == 0) wait_clk(4);
    cs = 1'b1;
    wait_clk(4);
    if (n == 16) begin
      exp_good++;
      exp_data = v[15:0];
      exp_q.push_back(v[15:0]);
    end else begin
      exp_err++;
    end
  endtask

  task automatic check_all(input string tag);
    wait_clk(4);
    chk({tag, "_valid_cnt"}, 32'(mon_valid), 32'(exp_good));
    chk({tag, "_err_cnt"}, 32'(mon_err), 32'(exp_err));
    chk({tag, "_both"}, 32'(mon_both), 32'd0);
    chk({tag, "_data"}, {16'b0, data}, {16'b0, exp_data});
    chk({tag, "_fcount"}, {24'b0, frame_count}, 32'(exp_good % 256));
    chk({tag, "_fcount2"}, {30'b0, frame_count2}, 32'(exp_good % 4));
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_qsize"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_word"}, {16'b0, got_q.pop_front()}, {16'b0, exp_q.pop_front()});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] r;
    int n;

    // 1: reset state and quiet release
    wait_clk(3);
    chk("rst_data", {16'b0, data}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_err", {31'b0, frame_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_fcount", {24'b0, frame_count}, 32'd0);
    rst = 1'b0;
    wait_clk(10);
    check_all("reset");

    // 2: single good frame
    frame(32'h0000_A5C3, 16);
    check_all("good");

    // 3: short, overrun, zero-bit and random bad-length frames
    frame(32'h0000_02AB, 10);
    frame(32'h0003_1234, 18);
    check_all("badlen");
    frame(32'h0, 0);
    n = int'($urandom_range(1, 15));
    frame($urandom, n);
    n = int'($urandom_range(17, 20));
    frame($urandom, n);
    check_all("badrand");

    // 4: back-to-back frames with minimum gap, then random words
    frame(32'h0000_0001, 16);
    frame(32'h0000_FFFF, 16);
    frame(32'h0000_8000, 16);
    for (int k = 0; k < 3; k++) begin
      r = $urandom;
      frame({16'b0, r[15:0]}, 16);
    end
    check_all("b2b");

    // 5: sclk/sdo activity with cs high
    for (int k = 0; k < 20; k++) begin
      sclk = 1'b0;
      sdo  = 1'($urandom);
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
    end
    check_all("csidle");

    // 6: reset mid-frame, then clean frames (CNT_W=2 copy wraps)
    cs = 1'b0;
    wait_clk(4);
    send_bits(32'h0000_00C7, 8);
    rst  = 1'b1;
    cs   = 1'b1;
    sclk = 1'b1;
    sdo  = 1'b0;
    exp_good = 0;
    exp_err  = 0;
    exp_data = '0;
    exp_q.delete();
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    frame(32'h0000_1234, 16);
    check_all("abort");
    for (int k = 0; k < 4; k++) begin
      r = $urandom;
      frame({16'b0, r[15:0]}, 16);
    end
    check_all("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

`default_nettype wire
